// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable data bits, parity
// and stop bits. It holds one word with a valid/ready handshake and reports
// frames dropped while a word is still held.
module uart_rx_cfg #(
  parameter int unsigned CLK_PER_BIT = 87,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rxdata,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 rts,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sync1;
  logic                 r_rxs;
  logic                 r_rxs_prev;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bitn;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr_acc;
  logic                 r_perr_acc;
  logic [DATA_BITS-1:0] r_rxdata;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_perr;
  logic                 r_overrun;
  logic                 r_rts;
  logic                 r_busy;
  logic                 w_bit_end;
  logic                 w_start;
  logic                 w_done;
  logic                 w_ferr_fin;
  logic                 w_accept;
  logic                 w_drop;

  // Two-flop synchroniser plus one extra sample for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1    <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync1    <= rxd;
      r_rxs      <= r_sync1;
      r_rxs_prev <= r_rxs;
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; START checks mid start bit, other states at bit centre
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_bit_end   = (r_cnt == FULL_M1);
    case (r_state)
      S_IDLE: begin
        if (r_rxs_prev && !r_rxs) begin
          w_state_nxt = S_START;
          w_start     = 1'b1;
        end
      end
      S_START: begin
        if (r_cnt == HALF_M1) w_state_nxt = r_rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && (r_bitn == DATA_LAST))
          w_state_nxt = (PARITY == 0) ? S_STOP : S_PARITY;
      end
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end && (r_bitn == STOP_LAST)) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timing, shift register and per-frame error accumulation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_bitn     <= '0;
      r_shift    <= '0;
      r_ferr_acc <= 1'b0;
      r_perr_acc <= 1'b0;
    end else begin
      if ((w_state_nxt != r_state) || w_bit_end || (r_state == S_IDLE))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);

      if (w_state_nxt != r_state)
        r_bitn <= '0;
      else if (w_bit_end && ((r_state == S_DATA) || (r_state == S_STOP)))
        r_bitn <= r_bitn + BIT_W'(1);

      if ((r_state == S_DATA) && w_bit_end)
        r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};

      if (w_start) begin
        r_ferr_acc <= 1'b0;
        r_perr_acc <= 1'b0;
      end else begin
        if ((r_state == S_PARITY) && w_bit_end)
          r_perr_acc <= (^r_shift) ^ r_rxs ^ (PARITY == 1);
        if ((r_state == S_STOP) && w_bit_end && !r_rxs)
          r_ferr_acc <= 1'b1;
      end
    end
  end

  assign w_ferr_fin = r_ferr_acc | ~r_rxs;
  assign w_accept   = r_valid & rx_ready;
  assign w_drop     = w_done & r_valid & ~rx_ready;

  // Output holding register, handshake, overrun flag and flow control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxdata  <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      r_overrun <= 1'b0;
      r_rts     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rts  <= ~r_valid;
      r_busy <= (w_state_nxt != S_IDLE);

      if (w_done && !w_drop) begin
        r_rxdata <= r_shift;
        r_ferr   <= w_ferr_fin;
        r_perr   <= r_perr_acc;
        r_valid  <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (w_drop)        r_overrun <= 1'b1;
      else if (w_accept) r_overrun <= 1'b0;
    end
  end

  assign rxdata     = r_rxdata;
  assign rx_valid   = r_valid;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign overrun    = r_overrun;
  assign rts        = r_rts;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance, each with a
// scoreboard queue filled by the line driver and drained by a monitor.
module tb_uart_rx_cfg;

  localparam int unsigned CPB = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rxd_a, rxd_b, rdy_a, rdy_b;
  logic [7:0] rxdata_a;
  logic [6:0] rxdata_b;
  logic       vld_a, ferr_a, perr_a, ovr_a, rts_a, busy_a;
  logic       vld_b, ferr_b, perr_b, ovr_b, rts_b, busy_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   held_a = 1'b0, held_b = 1'b0;
  logic exp_ovr_a = 1'b0, exp_ovr_b = 1'b0;

  uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .rxd(rxd_a), .rxdata(rxdata_a), .rx_valid(vld_a),
    .rx_ready(rdy_a), .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a),
    .rts(rts_a), .busy(busy_a));

  uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .rxd(rxd_b), .rxdata(rxdata_b), .rx_valid(vld_b),
    .rx_ready(rdy_b), .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b),
    .rts(rts_b), .busy(busy_b));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the receiver should report for a frame with these line bits
  function automatic exp_t model(input logic [8:0] data, input int nbits, input int par_mode,
                                 input logic pbit, input logic [1:0] stops, input int nstop);
    exp_t e;
    int   ones;
    ones   = 0;
    e.data = '0;
    for (int i = 0; i < nbits; i++) begin
      e.data[i] = data[i];
      if (data[i]) ones++;
    end
    if (pbit) ones++;
    e.perr = 1'b0;
    if (par_mode == 1) e.perr = ((ones % 2) == 0);
    if (par_mode == 2) e.perr = ((ones % 2) == 1);
    e.ferr = 1'b0;
    for (int s = 0; s < nstop; s++) if (!stops[s]) e.ferr = 1'b1;
    return e;
  endfunction

  task automatic drive_bit(input int which, input logic b);
    if (which == 0) rxd_a = b;
    else            rxd_b = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Predicts acceptance/drop from the held-word state, then drives the frame
  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int par_mode, input logic pbit, input logic [1:0] stops,
                            input int nstop, input logic end_level, input int gap);
    exp_t e;
    e = model(data, nbits, par_mode, pbit, stops, nstop);
    if (which == 0) begin
      if (rdy_a || !held_a) begin qa.push_back(e); held_a = !rdy_a; end
      else exp_ovr_a = 1'b1;
    end else begin
      if (rdy_b || !held_b) begin qb.push_back(e); held_b = !rdy_b; end
      else exp_ovr_b = 1'b1;
    end
    drive_bit(which, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(which, data[i]);
    if (par_mode != 0) drive_bit(which, pbit);
    for (int s = 0; s < nstop; s++) drive_bit(which, stops[s]);
    if (which == 0) rxd_a = end_level;
    else            rxd_b = end_level;
    repeat (gap) @(negedge clk);
  endtask

  // Monitor A: each new word is popped and compared; with ready high it must last one cycle
  initial begin : mon_a
    bit   prev;
    bit   pend;
    exp_t e;
    prev = 1'b0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("a_valid_one_cycle", 32'(vld_a), 32'(0));
        pend = 1'b0;
      end
      if (vld_a && !prev) begin
        check("a_word_expected", 32'(qa.size() != 0), 32'(1));
        if (qa.size() != 0) begin
          e = qa.pop_front();
          check("a_rxdata", 32'(rxdata_a), 32'(e.data));
          check("a_frame_err", 32'(ferr_a), 32'(e.ferr));
          check("a_parity_err", 32'(perr_a), 32'(e.perr));
          if (rdy_a) pend = 1'b1;
        end
      end
      prev = vld_a;
    end
  end

  // Monitor B: same scheme for the 7E2 instance
  initial begin : mon_b
    bit   prev;
    bit   pend;
    exp_t e;
    prev = 1'b0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("b_valid_one_cycle", 32'(vld_b), 32'(0));
        pend = 1'b0;
      end
      if (vld_b && !prev) begin
        check("b_word_expected", 32'(qb.size() != 0), 32'(1));
        if (qb.size() != 0) begin
          e = qb.pop_front();
          check("b_rxdata", 32'(rxdata_b), 32'(e.data));
          check("b_frame_err", 32'(ferr_b), 32'(e.ferr));
          check("b_parity_err", 32'(perr_b), 32'(e.perr));
          if (rdy_b) pend = 1'b1;
        end
      end
      prev = vld_b;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         cyc;
    logic [1:0] st;
    logic [7:0] d;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    repeat (3) @(negedge clk);
    check("a_reset_outputs", 32'({rxdata_a, vld_a, ferr_a, perr_a, ovr_a, rts_a, busy_a}), 32'(0));
    check("b_reset_outputs", 32'({rxdata_b, vld_b, ferr_b, perr_b, ovr_b, rts_b, busy_b}), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    check("a_rts_after_reset", 32'(rts_a), 32'(1));
    check("b_rts_after_reset", 32'(rts_b), 32'(1));
    repeat (5) @(negedge clk);

    // 8N1 basic word
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, 1'b1, 20);
    check("a_overrun_clear", 32'(ovr_a), 32'(exp_ovr_a));

    // Short low glitch: busy latency, then back to idle with no word
    rxd_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("a_busy_lat2", 32'(busy_a), 32'(0));
    @(negedge clk);
    check("a_busy_lat3", 32'(busy_a), 32'(1));
    @(negedge clk);
    rxd_a = 1'b1;
    cyc = 4;
    while (busy_a && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("a_glitch_busy_clear", 32'(cyc <= 11), 32'(1));
    repeat (20) @(negedge clk);

    // Random 8N1 words with occasional bad stop bit
    for (int k = 0; k < 12; k++) begin
      d     = 8'($urandom_range(0, 255));
      st    = 2'b11;
      st[0] = ($urandom_range(0, 7) != 0);
      send_frame(0, 9'(d), 8, 0, 1'b0, st, 1, 1'b1, 4 + int'($urandom_range(0, 20)));
    end

    // Bad stop bit followed by a long low line: one word only
    send_frame(0, 9'h055, 8, 0, 1'b0, 2'b00, 1, 1'b0, 40 * CPB);
    check("a_hold_low_no_valid", 32'(vld_a), 32'(0));
    check("a_hold_low_idle", 32'(busy_a), 32'(0));
    rxd_a = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 2'b11, 1, 1'b1, 20);

    // Overrun: consumer stalled across two words
    rdy_a = 1'b0;
    send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1, 1'b1, 10);
    send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1, 1'b1, 20);
    check("a_ovr_rxdata", 32'(rxdata_a), 32'h11);
    check("a_ovr_valid", 32'(vld_a), 32'(1));
    check("a_ovr_flag", 32'(ovr_a), 32'(exp_ovr_a));
    check("a_ovr_rts", 32'(rts_a), 32'(0));
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a     = 1'b0;
    held_a    = 1'b0;
    exp_ovr_a = 1'b0;
    check("a_accept_valid", 32'(vld_a), 32'(0));
    check("a_accept_ovr", 32'(ovr_a), 32'(exp_ovr_a));
    check("a_accept_rxdata_hold", 32'(rxdata_a), 32'h11);
    check("a_accept_rts_lag", 32'(rts_a), 32'(0));
    @(negedge clk);
    check("a_accept_rts", 32'(rts_a), 32'(1));
    rdy_a = 1'b1;
    repeat (5) @(negedge clk);

    // Reset in the middle of data bit 3 of 0xF0
    d = 8'hF0;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, d[i]);
    rxd_a = d[3];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("a_midframe_reset", 32'({rxdata_a, vld_a, ferr_a, perr_a, ovr_a, rts_a, busy_a}), 32'(0));
    rxd_a = 1'b1;
    repeat (3) @(negedge clk);
    check("a_reset_held", 32'({rxdata_a, vld_a, ferr_a, perr_a, ovr_a, rts_a, busy_a}), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    check("a_rts_after_rerelease", 32'(rts_a), 32'(1));
    repeat (5) @(negedge clk);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1, 1'b1, 20);

    // 7E2: parity error then good parity
    send_frame(1, 9'h003, 7, 2, 1'b1, 2'b11, 2, 1'b1, 20);
    send_frame(1, 9'h003, 7, 2, 1'b0, 2'b11, 2, 1'b1, 20);

    // Random 7E2 words with random parity bit and stop bits
    for (int k = 0; k < 12; k++) begin
      d     = 8'($urandom_range(0, 127));
      st[0] = ($urandom_range(0, 7) != 0);
      st[1] = ($urandom_range(0, 7) != 0);
      send_frame(1, 9'(d), 7, 2, 1'($urandom_range(0, 1)), st, 2, 1'b1,
                 4 + int'($urandom_range(0, 20)));
    end
    check("b_overrun", 32'(ovr_b), 32'(exp_ovr_b));

    repeat (50) @(negedge clk);
    check("a_queue_drained", 32'(qa.size()), 32'(0));
    check("b_queue_drained", 32'(qb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 87, clocks per serial bit; legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame; legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port rxd  input  1  asynchronous serial line; idles high.
REQ-008 SHALL have port rxdata  output  DATA_BITS  last received word, LSB first on the line.
REQ-009 SHALL have port rx_valid  output  1  rxdata, frame_err and parity_err hold a word.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts the word.
REQ-011 SHALL have port frame_err  output  1  a stop bit of the held word sampled 0.
REQ-012 SHALL have port parity_err  output  1  parity mismatch on the held word; always 0 when PARITY=0.
REQ-013 SHALL have port overrun  output  1  sticky: at least one frame was dropped.
REQ-014 SHALL have port rts  output  1  high = receiver can accept a frame.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL synchronise rxd through two flops (rxs); both flops reset to 1.
REQ-017 SHALL implement the states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL use a bit counter cnt of width clog2(CLK_PER_BIT), cleared on every state entry.
REQ-019 IDLE: SHALL go to START only on a falling edge of rxs (previous sample 1, current 0); a line held low never starts a frame.
REQ-020 START: at cnt==CLK_PER_BIT/2-1, SHALL go to DATA if rxs==0; if rxs==1 it is a glitch and SHALL go to IDLE with no output change.
REQ-021 DATA: SHALL sample rxs at cnt==CLK_PER_BIT-1 (bit centre) into the shift register, LSB first; after DATA_BITS samples, SHALL go to PARITY, or to STOP if PARITY==0.
REQ-022 PARITY: SHALL sample one bit at cnt==CLK_PER_BIT-1.
  - Error when XOR(data, parity bit) is not 1 (odd) or not 0 (even).
  - Then go to STOP.
REQ-023 STOP: SHALL sample STOP_BITS bits at bit centre; any 0 sample sets the frame error for that word.
REQ-024 After the last stop sample, SHALL complete the frame, go to IDLE, and begin start detection while the remainder of the stop bit is still on the line.
REQ-025 Frame completion with rx_valid==0, or with rx_valid&&rx_ready in the same cycle: SHALL load rxdata, frame_err and parity_err, and set rx_valid on the next clock.
REQ-026 Frame completion with rx_valid==1 && rx_ready==0: SHALL drop the new frame, keep the held word unchanged, and set overrun.
REQ-027 rx_valid&&rx_ready with no frame completing: SHALL clear rx_valid next clock; rxdata SHALL hold its value.
REQ-028 overrun SHALL clear on the next accepted handshake unless a drop occurs in that same cycle.
REQ-029 rts SHALL be registered as NOT rx_valid (one clock lag); deasserting rts SHALL NOT abort a frame in progress.
REQ-030 Latency:
  - rxd falling edge to busy=1 is 3 clocks.
  - last stop-bit sample to rx_valid=1 is 1 clock.

Reset
REQ-031 While reset==0, SHALL asynchronously force: state IDLE; cnt, shift register, rxdata 0; rx_valid, frame_err, parity_err, overrun, rts, busy 0; sync flops 1.
REQ-032 Reset mid-frame SHALL discard the partial frame; the first falling edge after release SHALL start a fresh frame.
REQ-033 rts SHALL rise on the first clock after reset release.

Verification (CLK_PER_BIT=16 unless stated)
REQ-034 8N1, send 0xA5, rx_ready=1 -> rx_valid high 1 cycle, rxdata=0xA5, frame_err=0, parity_err=0, overrun=0.
REQ-035 rxd low for 4 clocks then high -> no rx_valid; busy returns to 0 within 11 clocks.
REQ-036 PARITY=2, DATA_BITS=7, send 0x03 with parity bit 1 -> rx_valid, rxdata=0x03, parity_err=1; repeat with parity bit 0 -> parity_err=0.
REQ-037 Send 0x55 with stop bit 0, then hold rxd low 40 bit times -> one word, frame_err=1; no further rx_valid until rxd goes high and a new start bit arrives.
REQ-038 rx_ready=0, send 0x11 then 0x22 -> rxdata=0x11, overrun=1, rts=0; pulse rx_ready -> rx_valid=0, overrun=0, rts=1 one clock later.
REQ-039 Assert reset during data bit 3 of 0xF0, then release and send 0x3C -> all outputs 0 while reset is low; next word rxdata=0x3C with no errors.
